// File: rtl/task_priority_heap.sv
// Bounded min-priority queue built as a sorted shift-insert register array.
// The head slot always holds the minimum; every operation completes in one cycle.
module task_priority_heap #(
  parameter int unsigned N_STAGES       = 4,
  parameter int unsigned PRIORITY_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PRIORITY_WIDTH-1:0] in_ts,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [1:0]                in_op,
  output logic                      ready,
  output logic [PRIORITY_WIDTH-1:0] out_ts,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  output logic [N_STAGES-1:0]       capacity
);

  localparam int unsigned Depth = (1 << N_STAGES) - 1;
  localparam logic [N_STAGES-1:0] CountMax = N_STAGES'(Depth);

  typedef enum logic [1:0] {
    OpNop     = 2'd0,
    OpEnq     = 2'd1,
    OpDeq     = 2'd2,
    OpReplace = 2'd3
  } op_e;

  logic [PRIORITY_WIDTH-1:0] ts_q   [Depth];
  logic [PRIORITY_WIDTH-1:0] ts_d   [Depth];
  logic [DATA_WIDTH-1:0]     data_q [Depth];
  logic [DATA_WIDTH-1:0]     data_d [Depth];
  logic [PRIORITY_WIDTH-1:0] ts_next   [Depth];
  logic [DATA_WIDTH-1:0]     data_next [Depth];
  logic [PRIORITY_WIDTH-1:0] ts_prev   [Depth];
  logic [DATA_WIDTH-1:0]     data_prev [Depth];

  logic [N_STAGES-1:0]       count_q, count_d;
  logic                      ready_q;
  logic [PRIORITY_WIDTH-1:0] out_ts_q, out_ts_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;

  logic [Depth-1:0] valid;
  logic [Depth-1:0] le_cur;   // live slot i sorts at or before the input
  logic [Depth-1:0] le_rem;   // same, against the entries left after removing the head
  logic [Depth-1:0] ins_enq;
  logic [Depth-1:0] ins_rep;
  op_e              op;
  logic             do_enq, do_deq, do_rep;

  assign op     = op_e'(in_op);
  assign do_enq = ready_q && (op == OpEnq) && (count_q != CountMax);
  assign do_deq = ready_q && (op == OpDeq) && (count_q != '0);
  assign do_rep = ready_q && (op == OpReplace);

  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      valid[i]  = (i < 32'(count_q));
      le_cur[i] = valid[i] && (ts_q[i] <= in_ts);
    end
    // Insert position is the first slot whose predecessor still sorts before the input.
    le_rem  = {1'b0, le_cur[Depth-1:1]};
    ins_enq = ~le_cur & {le_cur[Depth-2:0], 1'b1};
    ins_rep = ~le_rem & {le_rem[Depth-2:0], 1'b1};
  end

  always_comb begin
    for (int unsigned i = 0; i < Depth - 1; i++) begin
      ts_next[i]   = ts_q[i+1];
      data_next[i] = data_q[i+1];
    end
    ts_next[Depth-1]   = ts_q[Depth-1];
    data_next[Depth-1] = data_q[Depth-1];
    ts_prev[0]   = ts_q[0];
    data_prev[0] = data_q[0];
    for (int unsigned i = 1; i < Depth; i++) begin
      ts_prev[i]   = ts_q[i-1];
      data_prev[i] = data_q[i-1];
    end
  end

  always_comb begin
    ts_d    = ts_q;
    data_d  = data_q;
    count_d = count_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (do_enq) begin
        if (le_cur[i]) begin
          ts_d[i]   = ts_q[i];
          data_d[i] = data_q[i];
        end else if (ins_enq[i]) begin
          ts_d[i]   = in_ts;
          data_d[i] = in_data;
        end else begin
          ts_d[i]   = ts_prev[i];
          data_d[i] = data_prev[i];
        end
      end else if (do_deq) begin
        ts_d[i]   = ts_next[i];
        data_d[i] = data_next[i];
      end else if (do_rep) begin
        // Shift-up then shift-down cancels out for slots past the insert point.
        if (le_rem[i]) begin
          ts_d[i]   = ts_next[i];
          data_d[i] = data_next[i];
        end else if (ins_rep[i]) begin
          ts_d[i]   = in_ts;
          data_d[i] = in_data;
        end
      end
    end
    if (do_enq) begin
      count_d = count_q + N_STAGES'(1);
    end else if (do_deq) begin
      count_d = count_q - N_STAGES'(1);
    end else if (do_rep && (count_q == '0)) begin
      count_d = N_STAGES'(1);
    end
  end

  always_comb begin
    out_ts_d   = '1;
    out_data_d = '1;
    if (count_d != '0) begin
      out_ts_d   = ts_d[0];
      out_data_d = data_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      count_q    <= '0;
      out_ts_q   <= '1;
      out_data_q <= '1;
    end else begin
      ready_q    <= 1'b1;
      count_q    <= count_d;
      out_ts_q   <= out_ts_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage beyond count is don't-care, so the slots themselves need no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_q   <= ts_d;
      data_q <= data_d;
    end
  end

  assign ready     = ready_q;
  assign out_ts    = out_ts_q;
  assign out_data  = out_data_q;
  assign out_valid = (count_q != '0);
  assign capacity  = CountMax - count_q;

endmodule

// File: tb/tb_task_priority_heap.sv
// Directed bench for task_priority_heap: the driver queues hand-computed expectations,
// a monitor pops one per clock and compares it against the registered outputs.
module tb_task_priority_heap;

  localparam logic [1:0] NOP = 2'd0, ENQ = 2'd1, DEQ = 2'd2, REP = 2'd3;
  localparam logic [31:0]  TsE  = 32'hFFFF_FFFF;
  localparam logic [127:0] DatE = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_ts;
  logic [127:0] in_data;
  logic [1:0]   in_op;
  logic         ready;
  logic [31:0]  out_ts;
  logic [127:0] out_data;
  logic         out_valid;
  logic [3:0]   capacity;

  typedef struct {
    int           id;
    logic         rdy;
    logic         vld;
    logic [31:0]  ts;
    logic [127:0] data;
    logic [3:0]   cap;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  task_priority_heap #(
    .N_STAGES(4),
    .PRIORITY_WIDTH(32),
    .DATA_WIDTH(128)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_ts    (in_ts),
    .in_data  (in_data),
    .in_op    (in_op),
    .ready    (ready),
    .out_ts   (out_ts),
    .out_data (out_data),
    .out_valid(out_valid),
    .capacity (capacity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, id, act, req);
    end
  endtask

  // Monitor: every expectation applies to the outputs right after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ready", e.id, 128'(ready), 128'(e.rdy));
        chk("out_valid", e.id, 128'(out_valid), 128'(e.vld));
        chk("capacity", e.id, 128'(capacity), 128'(e.cap));
        chk("out_ts", e.id, 128'(out_ts), 128'(e.ts));
        chk("out_data", e.id, out_data, e.data);
      end
    end
  end

  // Called at a falling edge: drive one cycle of stimulus and queue its expected outcome.
  task automatic step(input logic r, input logic [1:0] op, input logic [31:0] ts,
                      input logic [127:0] d, input logic ev, input logic [31:0] ets,
                      input logic [127:0] edata, input logic [3:0] ecap);
    exp_t e;
    rst     = r;
    in_op   = op;
    in_ts   = ts;
    in_data = d;
    e.id    = step_id;
    e.rdy   = !r;
    e.vld   = ev;
    e.ts    = ets;
    e.data  = edata;
    e.cap   = ecap;
    exp_q.push_back(e);
    step_id++;
    @(negedge clk);
  endtask

  task automatic step_empty(input logic r, input logic [1:0] op, input logic [31:0] ts);
    step(r, op, ts, 128'h0, 1'b0, TsE, DatE, 4'd15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d actual=timeout required=finish", step_id);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_op = NOP; in_ts = '0; in_data = '0;
    @(negedge clk);

    // Reset, then idle; an op presented while ready=0 must be ignored.
    step_empty(1'b1, NOP, 32'd0);
    step_empty(1'b0, ENQ, 32'd4);
    step_empty(1'b0, NOP, 32'd0);

    // Basic ordering.
    step(1'b0, ENQ, 32'd5, 128'hA, 1'b1, 32'd5, 128'hA, 4'd14);
    step(1'b0, ENQ, 32'd3, 128'hB, 1'b1, 32'd3, 128'hB, 4'd13);
    step(1'b0, ENQ, 32'd9, 128'hC, 1'b1, 32'd3, 128'hB, 4'd12);
    step(1'b0, DEQ, 32'd0, 128'h0, 1'b1, 32'd5, 128'hA, 4'd13);
    step(1'b0, DEQ, 32'd0, 128'h0, 1'b1, 32'd9, 128'hC, 4'd14);
    step_empty(1'b0, DEQ, 32'd0);

    // Fill with descending priorities, overflow, then REPLACE while full.
    for (int j = 0; j < 15; j++) begin
      step(1'b0, ENQ, 32'(15 - j), 128'(100 + j), 1'b1, 32'(15 - j), 128'(100 + j),
           4'(14 - j));
    end
    step(1'b0, ENQ, 32'd0, 128'h99, 1'b1, 32'd1, 128'd114, 4'd0);
    step(1'b0, REP, 32'd0, 128'd200, 1'b1, 32'd0, 128'd200, 4'd0);
    step(1'b0, DEQ, 32'd0, 128'h0, 1'b1, 32'd2, 128'd113, 4'd1);
    step_empty(1'b1, NOP, 32'd0);
    step_empty(1'b0, NOP, 32'd0);

    // FIFO among equal priorities.
    step(1'b0, ENQ, 32'd7, 128'hF1, 1'b1, 32'd7, 128'hF1, 4'd14);
    step(1'b0, ENQ, 32'd7, 128'hF2, 1'b1, 32'd7, 128'hF1, 4'd13);
    step(1'b0, ENQ, 32'd7, 128'hF3, 1'b1, 32'd7, 128'hF1, 4'd12);
    step(1'b0, DEQ, 32'd0, 128'h0, 1'b1, 32'd7, 128'hF2, 4'd13);
    step(1'b0, DEQ, 32'd0, 128'h0, 1'b1, 32'd7, 128'hF3, 4'd14);
    step_empty(1'b0, DEQ, 32'd0);

    // REPLACE behind and in front of the remaining entries.
    step(1'b0, ENQ, 32'd4, 128'hD, 1'b1, 32'd4, 128'hD, 4'd14);
    step(1'b0, ENQ, 32'd8, 128'hE, 1'b1, 32'd4, 128'hD, 4'd13);
    step(1'b0, REP, 32'd6, 128'hF, 1'b1, 32'd6, 128'hF, 4'd13);
    step(1'b0, DEQ, 32'd0, 128'h0, 1'b1, 32'd8, 128'hE, 4'd14);
    step(1'b0, ENQ, 32'd6, 128'hF, 1'b1, 32'd6, 128'hF, 4'd13);
    step(1'b0, REP, 32'd2, 128'h6, 1'b1, 32'd2, 128'h6, 4'd13);
    step(1'b0, DEQ, 32'd0, 128'h0, 1'b1, 32'd8, 128'hE, 4'd14);
    step_empty(1'b0, DEQ, 32'd0);
    step_empty(1'b0, DEQ, 32'd0);
    step(1'b0, REP, 32'd11, 128'h11, 1'b1, 32'd11, 128'h11, 4'd14);
    step_empty(1'b0, DEQ, 32'd0);

    // Reset with five entries held and an ENQ presented.
    for (int j = 1; j <= 5; j++) begin
      step(1'b0, ENQ, 32'(j), 128'(j), 1'b1, 32'd1, 128'd1, 4'(15 - j));
    end
    step_empty(1'b1, ENQ, 32'd0);
    step_empty(1'b0, NOP, 32'd0);
    step_empty(1'b0, NOP, 32'd0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/task_priority_heap.md
Name: task_priority_heap

Overview:
Bounded min-priority queue holding up to 2^N_STAGES-1 (priority, payload) entries. It is the task staging buffer in front of the splitter: the splitter enqueues incoming spill tasks and dequeues the lowest-timestamp task when it is ready to process one. Every operation completes in one cycle. Internally it is a sorted register array (shift-insert), so the minimum is always available at the head.

Parameters:
N_STAGES, 4, log2 of storage depth; capacity is 2^N_STAGES-1 entries (15 by default).
PRIORITY_WIDTH, 32, priority (timestamp) width; smaller value means higher priority.
DATA_WIDTH, 128, payload width.

Ports:
clk  in  1  sole clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_ts  in  PRIORITY_WIDTH  priority of the entry being inserted.
in_data  in  DATA_WIDTH  payload of the entry being inserted.
in_op  in  2  operation: 0=NOP, 1=ENQ, 2=DEQ_MIN, 3=REPLACE.
ready  out  1  operations are accepted only while high.
out_ts  out  PRIORITY_WIDTH  priority of the current minimum entry.
out_data  out  DATA_WIDTH  payload of the current minimum entry.
out_valid  out  1  heap is non-empty.
capacity  out  N_STAGES  free slots, equal to 2^N_STAGES-1-count.

Behaviour:
- Reset (rst high at a clock edge):
  - count=0, out_valid=0, capacity=2^N_STAGES-1, ready=0.
  - out_ts and out_data are forced to all-ones.
  - Reset mid-operation discards all contents; the op in that cycle is ignored.
- ready is a register: 0 during reset, 1 from the first edge after rst deasserts, then stays 1. in_op is ignored while ready=0.
- All outputs are registered. The effect of an op sampled at edge k is visible on the outputs right after edge k.
- out_ts/out_data always show the head (minimum) entry. When empty they are all-ones.
- ENQ:
  - Inserts (in_ts, in_data) in sorted position; count+1.
  - Ties: the new entry goes after all existing entries of equal priority (FIFO among equals).
  - ENQ when full (count=2^N_STAGES-1) is dropped with no state change.
- DEQ_MIN:
  - Removes the head and shifts the remaining entries up; count-1.
  - The removed entry is the one on out_ts/out_data in the same cycle. The caller captures it combinationally in the same cycle it issues DEQ_MIN.
  - DEQ_MIN when empty is ignored.
- REPLACE:
  - Atomically removes the head and inserts the input; count is unchanged.
  - The insert compares only against the remaining entries, so the input may become the new head.
  - When empty, REPLACE behaves as ENQ.
  - When full, REPLACE is legal.
- NOP: no state change.
- capacity and out_valid update in the same cycle as count.
- Slots beyond count hold don't-care values and never appear on the outputs.
- Implementation: each slot's next value is selected from {hold, previous slot, next slot, input} by a per-slot comparison of in_ts against the slot's priority, plus the op. No multi-cycle state machine.

Test Plan:
- Reset, then idle: ready=1 after one cycle, out_valid=0, capacity=15, out_ts=0xFFFFFFFF.
- ENQ ts 5, 3, 9 (payloads A, B, C) on consecutive cycles: out_ts=3/out_data=B, capacity=12. DEQ_MIN: head becomes 5/A. DEQ_MIN again: head becomes 9/C.
- ENQ 15 entries with ts 15 down to 1: capacity=0, head=1. A 16th ENQ of ts 0 is dropped (head stays 1, capacity 0). REPLACE ts 0 then gives head=0, capacity=0.
- ENQ ts 7 with payloads X, Y, Z: successive DEQ_MINs return X, Y, Z in that order.
- With contents {4, 8}:
  - REPLACE ts 6 leaves head=6, then 8.
  - REPLACE ts 2 on {6, 8} leaves head=2.
  - DEQ_MIN on empty: no change, out_valid stays 0.
- Assert rst while 5 entries are held and an ENQ is presented: next cycle count=0, capacity=15, out_valid=0, and the ENQ is lost.
